mem_port_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the single shared 256x16 RAM port.
- Masters: the CPU control FSM (master 0) and a DMA/loader engine (master 1).
- Converts per-master req/ack transactions into the timed mem_cmd / mem_addr / write_data sequence expected by the RAM read/write gating logic.
- Enforces the address-space rule: reads only to mem_addr[8]=0, writes only to mem_addr[8]=1.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates two masters (CPU = master 0, DMA = master 1) onto the single
//   shared RAM port. It sequences each granted transaction into the
//   mem_cmd / mem_addr / write_data timing that the RAM gating expects, and
//   turns any access outside the read/write address spaces into an error ack.
//
// Ports
//   clk_i, reset_n_i             clock, synchronous active-low reset
//   cpu_req_i/cmd_i/addr_i/wdata_i  CPU request (held until cpu_ack_o)
//   cpu_ack_o/err_o/rdata_o         CPU completion pulse, error flag, read data
//   dma_*                           same set of signals for the DMA master
//   mem_cmd_o, mem_addr_o, write_data_o  drive the RAM gating (10 rd, 01 wr, 00 idle)
//   read_data_i                     RAM read data, valid in the cycle after the address
//   busy_o                          high whenever a transaction is in flight
module mem_port_arbiter #(
  parameter int unsigned AW   = 9,
  parameter int unsigned DW   = 16,
  parameter int unsigned FAIR = 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          cpu_req_i,
  input  logic [1:0]    cpu_cmd_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic          cpu_err_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          dma_req_i,
  input  logic [1:0]    dma_cmd_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_ack_o,
  output logic          dma_err_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic [1:0]    mem_cmd_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] write_data_o,
  input  logic [DW-1:0] read_data_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [1:0] MREAD  = 2'b10;
  localparam logic [1:0] MWRITE = 2'b01;

  state_e        state_q, state_d;
  logic          grant_q;        // 0 = CPU, 1 = DMA
  logic          last_q;         // master granted most recently
  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

  logic take, win_dma;
  logic is_read, is_write, legal, rd_ok;

  assign is_read  = (cmd_q == MREAD);
  assign is_write = (cmd_q == MWRITE);
  assign legal    = (is_read && !addr_q[AW-1]) || (is_write && addr_q[AW-1]);
  assign rd_ok    = legal && is_read;

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state and arbitration
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    win_dma = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          take = 1'b1;
          if (cpu_req_i && dma_req_i) win_dma = (FAIR != 0) ? ~last_q : 1'b0;
          else                        win_dma = dma_req_i;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = rd_ok ? WAIT : DONE;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch, read-data capture and grant history
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      grant_q     <= 1'b0;
      last_q      <= 1'b1;   // DMA "last", so the CPU wins the first tie
      cmd_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (take) begin
        grant_q <= win_dma;
        cmd_q   <= win_dma ? dma_cmd_i   : cpu_cmd_i;
        addr_q  <= win_dma ? dma_addr_i  : cpu_addr_i;
        wdata_q <= win_dma ? dma_wdata_i : cpu_wdata_i;
      end
      if (state_q == WAIT) begin
        if (grant_q) dma_rdata_q <= read_data_i;
        else         cpu_rdata_q <= read_data_i;
      end
      if (state_q == DONE) last_q <= grant_q;
    end
  end

  // Outputs
  always_comb begin
    mem_cmd_o    = '0;
    mem_addr_o   = '0;
    write_data_o = '0;
    cpu_ack_o    = 1'b0;
    dma_ack_o    = 1'b0;
    cpu_err_o    = 1'b0;
    dma_err_o    = 1'b0;
    cpu_rdata_o  = cpu_rdata_q;
    dma_rdata_o  = dma_rdata_q;
    busy_o       = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        mem_addr_o = addr_q;
        if (legal) mem_cmd_o = cmd_q;   // legal implies 10 or 01, never 11
        if (legal && is_write) write_data_o = wdata_q;
      end
      WAIT: begin
        mem_cmd_o  = MREAD;
        mem_addr_o = addr_q;
      end
      DONE: begin
        cpu_ack_o = ~grant_q;
        dma_ack_o = grant_q;
        cpu_err_o = ~grant_q & ~legal;
        dma_err_o = grant_q & ~legal;
        // Read data registers keep their last read value, but a write or
        // error ack must present zero on the acknowledged master's rdata.
        if (!rd_ok) begin
          if (grant_q) dma_rdata_o = '0;
          else         cpu_rdata_o = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Two instances share all inputs:
//   u_fair (round-robin) and u_fix (CPU fixed priority). Inputs change 1 ns
//   after a rising edge; outputs are checked in the same window.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  logic          clk, reset_n;
  logic          cpu_req, dma_req;
  logic [1:0]    cpu_cmd, dma_cmd;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, read_data;

  logic          f_cpu_ack, f_cpu_err, f_dma_ack, f_dma_err, f_busy;
  logic [DW-1:0] f_cpu_rdata, f_dma_rdata, f_wdata;
  logic [1:0]    f_cmd;
  logic [AW-1:0] f_addr;
  logic          x_cpu_ack, x_cpu_err, x_dma_ack, x_dma_err, x_busy;
  logic [DW-1:0] x_cpu_rdata, x_dma_rdata, x_wdata;
  logic [1:0]    x_cmd;
  logic [AW-1:0] x_addr;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .FAIR(1)) u_fair (
    .clk_i(clk), .reset_n_i(reset_n),
    .cpu_req_i(cpu_req), .cpu_cmd_i(cpu_cmd), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(f_cpu_ack), .cpu_err_o(f_cpu_err), .cpu_rdata_o(f_cpu_rdata),
    .dma_req_i(dma_req), .dma_cmd_i(dma_cmd), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_ack_o(f_dma_ack), .dma_err_o(f_dma_err), .dma_rdata_o(f_dma_rdata),
    .mem_cmd_o(f_cmd), .mem_addr_o(f_addr), .write_data_o(f_wdata),
    .read_data_i(read_data), .busy_o(f_busy)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .FAIR(0)) u_fix (
    .clk_i(clk), .reset_n_i(reset_n),
    .cpu_req_i(cpu_req), .cpu_cmd_i(cpu_cmd), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(x_cpu_ack), .cpu_err_o(x_cpu_err), .cpu_rdata_o(x_cpu_rdata),
    .dma_req_i(dma_req), .dma_cmd_i(dma_cmd), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_ack_o(x_dma_ack), .dma_err_o(x_dma_err), .dma_rdata_o(x_dma_rdata),
    .mem_cmd_o(x_cmd), .mem_addr_o(x_addr), .write_data_o(x_wdata),
    .read_data_i(read_data), .busy_o(x_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #50000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_cmd = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_cmd = 2'b00; dma_addr = '0; dma_wdata = '0;
    read_data = '0;
    #1;
    do_reset();

    // Reset state
    chk("rst_mem_cmd", f_cmd, 2'b00);
    chk("rst_mem_addr", f_addr, 9'h000);
    chk("rst_wdata", f_wdata, 16'h0000);
    chk("rst_busy", f_busy, 1'b0);
    chk("rst_acks", {f_cpu_ack, f_cpu_err, f_dma_ack, f_dma_err}, 4'b0000);
    chk("rst_rdata", {f_cpu_rdata, f_dma_rdata}, 32'h0);

    // Single CPU write
    cpu_req = 1'b1; cpu_cmd = 2'b01; cpu_addr = 9'h105; cpu_wdata = 16'hBEEF;
    step();  // cycle 1
    chk("wr_c1_cmd", f_cmd, 2'b01);
    chk("wr_c1_addr", f_addr, 9'h105);
    chk("wr_c1_wdata", f_wdata, 16'hBEEF);
    chk("wr_c1_ack", f_cpu_ack, 1'b0);
    chk("wr_c1_busy", f_busy, 1'b1);
    step();  // cycle 2
    chk("wr_c2_cmd", f_cmd, 2'b00);
    chk("wr_c2_wdata", f_wdata, 16'h0000);
    chk("wr_c2_ack", {f_cpu_ack, f_cpu_err}, 2'b10);
    chk("wr_c2_dma_ack", f_dma_ack, 1'b0);
    cpu_req = 1'b0;
    step();  // idle
    chk("wr_c3_ack", f_cpu_ack, 1'b0);
    chk("wr_c3_busy", f_busy, 1'b0);

    // Single DMA read
    dma_req = 1'b1; dma_cmd = 2'b10; dma_addr = 9'h042; read_data = 16'h1234;
    step();  // cycle 1
    chk("rd_c1_cmd", f_cmd, 2'b10);
    chk("rd_c1_addr", f_addr, 9'h042);
    chk("rd_c1_busy", f_busy, 1'b1);
    step();  // cycle 2
    chk("rd_c2_cmd", f_cmd, 2'b10);
    chk("rd_c2_addr", f_addr, 9'h042);
    chk("rd_c2_ack", f_dma_ack, 1'b0);
    step();  // cycle 3
    chk("rd_c3_cmd", f_cmd, 2'b00);
    chk("rd_c3_ack", {f_dma_ack, f_dma_err, f_cpu_ack}, 3'b100);
    chk("rd_c3_rdata", f_dma_rdata, 16'h1234);
    chk("rd_c3_busy", f_busy, 1'b1);
    dma_req = 1'b0; read_data = 16'h0000;
    step();
    chk("rd_idle_busy", f_busy, 1'b0);
    chk("rd_hold_rdata", f_dma_rdata, 16'h1234);

    // Legal CPU read so the following error ack has nonzero rdata to hide
    cpu_req = 1'b1; cpu_cmd = 2'b10; cpu_addr = 9'h0A0; read_data = 16'h5A5A;
    step(); step(); step();
    chk("cpu_rd_ack", {f_cpu_ack, f_cpu_err}, 2'b10);
    chk("cpu_rd_rdata", f_cpu_rdata, 16'h5A5A);
    cpu_req = 1'b0; read_data = 16'h0000;
    step();

    // Illegal: read into write space, write into read space, cmd 11
    for (int k = 0; k < 3; k++) begin
      cpu_req = 1'b1;
      cpu_cmd   = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b11;
      cpu_addr  = (k == 0) ? 9'h142 : (k == 1) ? 9'h010 : 9'h105;
      cpu_wdata = 16'hDEAD;
      step();  // cycle 1
      chk("err_c1_cmd", f_cmd, 2'b00);
      chk("err_c1_wdata", f_wdata, 16'h0000);
      step();  // cycle 2
      chk("err_c2_cmd", f_cmd, 2'b00);
      chk("err_c2_ack", {f_cpu_ack, f_cpu_err}, 2'b11);
      chk("err_c2_rdata", f_cpu_rdata, 16'h0000);
      chk("err_c2_dma_ack", f_dma_ack, 1'b0);
      cpu_req = 1'b0;
      step();
    end
    chk("err_rdata_held", f_cpu_rdata, 16'h5A5A);

    // Contention: both masters hold back-to-back reads
    do_reset();
    cpu_req = 1'b1; cpu_cmd = 2'b10; cpu_addr = 9'h010;
    dma_req = 1'b1; dma_cmd = 2'b10; dma_addr = 9'h020;
    read_data = 16'h7777;
    for (int c = 1; c <= 19; c++) begin
      step();
      chk("fair_cpu_ack", f_cpu_ack, (c == 3 || c == 11) ? 1 : 0);
      chk("fair_dma_ack", f_dma_ack, (c == 7 || c == 15 || c == 19) ? 1 : 0);
      chk("fair_both_ack", f_cpu_ack & f_dma_ack, 1'b0);
      chk("fix_cpu_ack", x_cpu_ack, (c == 3 || c == 7 || c == 11 || c == 15) ? 1 : 0);
      chk("fix_dma_ack", x_dma_ack, (c == 19) ? 1 : 0);
      if (c == 1)  chk("fair_addr_c1", f_addr, 9'h010);
      if (c == 5)  chk("fair_addr_c5", f_addr, 9'h020);
      if (c == 5)  chk("fix_addr_c5", x_addr, 9'h010);
      if (c == 7)  chk("fair_dma_rdata", f_dma_rdata, 16'h7777);
      if (c == 15) cpu_req = 1'b0;
      if (c == 19) dma_req = 1'b0;
    end

    // Reset during WAIT of a CPU read
    do_reset();
    step();
    cpu_req = 1'b1; cpu_cmd = 2'b10; cpu_addr = 9'h033; read_data = 16'h4321;
    step();  // ISSUE
    step();  // WAIT
    chk("rst_mid_wait_cmd", f_cmd, 2'b10);
    reset_n = 1'b0;
    step();
    chk("rst_mid_cmd", f_cmd, 2'b00);
    chk("rst_mid_ack", f_cpu_ack, 1'b0);
    chk("rst_mid_busy", f_busy, 1'b0);
    chk("rst_mid_rdata", f_cpu_rdata, 16'h0000);
    reset_n = 1'b1;
    step();  // cycle 1 of re-request
    chk("rereq_c1_cmd", f_cmd, 2'b10);
    step();
    chk("rereq_c2_ack", f_cpu_ack, 1'b0);
    step();
    chk("rereq_c3_ack", {f_cpu_ack, f_cpu_err}, 2'b10);
    chk("rereq_c3_rdata", f_cpu_rdata, 16'h4321);
    cpu_req = 1'b0;
    step();
    chk("rereq_idle", f_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
